// File: rtl/hilo_pkg.sv
// Shared opcodes, state encoding and op decode for the HI/LO register unit.
package hilo_pkg;

   localparam logic [5:0] OP_MFHI  = 6'h10;
   localparam logic [5:0] OP_MTHI  = 6'h11;
   localparam logic [5:0] OP_MFLO  = 6'h12;
   localparam logic [5:0] OP_MTLO  = 6'h13;
   localparam logic [5:0] OP_MULT  = 6'h18;
   localparam logic [5:0] OP_MULTU = 6'h19;
   localparam logic [5:0] OP_DIV   = 6'h1A;
   localparam logic [5:0] OP_DIVU  = 6'h1B;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} hilo_state_t;

   function automatic logic is_hilo_op(input logic [5:0] op);
      case (op)
         OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO,
         OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/hilo_latency_counter.sv
// Load/decrement countdown; done marks the final cycle (count == 1) of a latency window.
module hilo_latency_counter #(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (!reset_n)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (count != '0)
         count <= count - 1'b1;
   end

   assign done = (count == CNT_W'(1));

endmodule

// File: rtl/hilo_register_unit.sv
// HI/LO architectural registers with modelled mult/div latency, MF*/MT* access and stall.
// Optional build macro HILO_FORWARD_EN: forward the pending result to MFHI/MFLO in the last busy cycle.
module hilo_register_unit
   import hilo_pkg::*;
#(
   parameter int MULT_LATENCY = 4,
   parameter int DIV_LATENCY  = 32
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [5:0]  ALU_operation,
   input  logic        op_valid,
   input  logic [31:0] ALU_HI_output,
   input  logic [31:0] ALU_LO_output,
   input  logic [31:0] operand_2,
   input  logic [31:0] mt_data,
   output logic [31:0] read_data,
   output logic        read_valid,
   output logic        stall,
   output logic        busy
);

   localparam int MAX_LAT = (MULT_LATENCY > DIV_LATENCY) ? MULT_LATENCY : DIV_LATENCY;
   localparam int CNT_W   = $clog2(MAX_LAT) + 1;

`ifdef HILO_FORWARD_EN
   localparam logic FWD_EN = 1'b1;
`else
   localparam logic FWD_EN = 1'b0;
`endif

   hilo_state_t      state, next_state;
   logic [31:0]      hi_q, lo_q, pend_hi_q, pend_lo_q;
   logic             done, cnt_load;
   logic [CNT_W-1:0] cnt_load_val;
   logic             hilo_op, is_mf, is_mul, is_div, fwd_ok, accept;

   assign hilo_op = op_valid & is_hilo_op(ALU_operation);
   assign is_mf   = (ALU_operation == OP_MFHI) | (ALU_operation == OP_MFLO);
   assign is_mul  = (ALU_operation == OP_MULT) | (ALU_operation == OP_MULTU);
   assign is_div  = (ALU_operation == OP_DIV)  | (ALU_operation == OP_DIVU);

   // Only reads may slip into the last busy cycle, and only when forwarding is built in.
   assign fwd_ok  = FWD_EN & is_mf & (state == BUSY) & done;
   assign accept  = hilo_op & ((state == IDLE) | fwd_ok);

   // A zero divisor is accepted but never starts a countdown, leaving HI/LO untouched.
   assign cnt_load     = accept & (state == IDLE) & (is_mul | (is_div & (operand_2 != '0)));
   assign cnt_load_val = is_div ? CNT_W'(DIV_LATENCY) : CNT_W'(MULT_LATENCY);

   hilo_latency_counter #(.CNT_W(CNT_W)) u_counter (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .done     (done)
   );

   always_ff @(posedge clk) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (cnt_load) next_state = BUSY;
         BUSY:    if (done)     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state == BUSY);
      stall      = hilo_op & ~accept;
      read_valid = accept & is_mf;
      read_data  = '0;
      if (read_valid) begin
         if (state == BUSY)
            read_data = (ALU_operation == OP_MFHI) ? pend_hi_q : pend_lo_q;
         else
            read_data = (ALU_operation == OP_MFHI) ? hi_q : lo_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
      end else begin
         if (state == BUSY && done) begin
            hi_q <= pend_hi_q;
            lo_q <= pend_lo_q;
         end else if (accept && state == IDLE) begin
            if (ALU_operation == OP_MTHI) hi_q <= mt_data;
            if (ALU_operation == OP_MTLO) lo_q <= mt_data;
         end
         if (cnt_load) begin
            pend_hi_q <= ALU_HI_output;
            pend_lo_q <= ALU_LO_output;
         end
      end
   end

endmodule

// File: tb/tb_hilo_register_unit.sv
// Randomized and directed bench for hilo_register_unit against a cycle-numbered reference model.
module tb_hilo_register_unit;

   localparam int ML = 4;
   localparam int DL = 32;
`ifdef HILO_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic [5:0]  ALU_operation;
   logic        op_valid;
   logic [31:0] ALU_HI_output, ALU_LO_output, operand_2, mt_data;
   logic [31:0] read_data;
   logic        read_valid, stall, busy;

   always #5 clk = ~clk;

   hilo_register_unit #(.MULT_LATENCY(ML), .DIV_LATENCY(DL)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .ALU_operation (ALU_operation),
      .op_valid      (op_valid),
      .ALU_HI_output (ALU_HI_output),
      .ALU_LO_output (ALU_LO_output),
      .operand_2     (operand_2),
      .mt_data       (mt_data),
      .read_data     (read_data),
      .read_valid    (read_valid),
      .stall         (stall),
      .busy          (busy)
   );

   int tests = 0;
   int fails = 0;

   // Reference model: architectural HI/LO plus an outstanding result due at an absolute cycle.
   int          cyc = 0;
   bit          model_ok = 0;
   bit          pend = 0;
   int          commit_at = 0;
   logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;

   logic [31:0] s_rd;
   logic        s_rv, s_stall, s_busy;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic bit m_is_hilo(input logic [5:0] op);
      return op inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B};
   endfunction

   task automatic step(input logic [5:0] op, input logic v, input logic [31:0] h, input logic [31:0] l,
                       input logic [31:0] o2, input logic [31:0] mt, input logic rn);
      bit          hilo, mf, ok, e_stall, e_rv;
      logic [31:0] e_rd;
      ALU_operation = op;  op_valid = v;  ALU_HI_output = h;  ALU_LO_output = l;
      operand_2 = o2;      mt_data = mt;  reset_n = rn;
      hilo = v && m_is_hilo(op);
      mf   = (op == 6'h10) || (op == 6'h12);
      ok   = !pend || (FWD && mf && cyc == commit_at);
      @(negedge clk);
      s_rd = read_data;  s_rv = read_valid;  s_stall = stall;  s_busy = busy;
      if (rn && model_ok) begin
         e_stall = hilo && !ok;
         e_rv    = hilo && mf && ok;
         e_rd    = 32'h0;
         if (e_rv) begin
            if (pend) e_rd = (op == 6'h10) ? m_phi : m_plo;
            else      e_rd = (op == 6'h10) ? m_hi  : m_lo;
         end
         check("busy", {31'b0, s_busy}, {31'b0, pend});
         check("stall", {31'b0, s_stall}, {31'b0, e_stall});
         check("read_valid", {31'b0, s_rv}, {31'b0, e_rv});
         check("read_data", s_rd, e_rd);
      end
      @(posedge clk);
      if (!rn) begin
         model_ok = 1;  pend = 0;  m_hi = 0;  m_lo = 0;  m_phi = 0;  m_plo = 0;
      end else if (pend && cyc == commit_at) begin
         m_hi = m_phi;  m_lo = m_plo;  pend = 0;
      end else if (hilo && ok && !pend) begin
         case (op)
            6'h11: m_hi = mt;
            6'h13: m_lo = mt;
            6'h18, 6'h19: begin pend = 1; m_phi = h; m_plo = l; commit_at = cyc + ML; end
            6'h1A, 6'h1B: if (o2 != 0) begin pend = 1; m_phi = h; m_plo = l; commit_at = cyc + DL; end
            default: ;
         endcase
      end
      cyc++;
      #1;
   endtask

   task automatic nop(input logic rn);
      step(6'h20, 1'b0, 32'h0, 32'h0, 32'h1, 32'h0, rn);
   endtask

   logic [5:0] ops [10] = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h20, 6'h00};

   initial begin
      int n;
      logic [31:0] o2;
      ALU_operation = 0; op_valid = 0; ALU_HI_output = 0; ALU_LO_output = 0;
      operand_2 = 0; mt_data = 0; reset_n = 0;
      #1;
      nop(1'b0);
      nop(1'b0);

      // Reset state, then reads of both registers.
      nop(1'b1);
      check("reset_busy", {31'b0, s_busy}, 32'h0);
      step(6'h10, 1, 0, 0, 1, 0, 1);
      check("t1_mfhi_data", s_rd, 32'h0);
      check("t1_mfhi_valid", {31'b0, s_rv}, 32'h1);
      check("t1_mfhi_stall", {31'b0, s_stall}, 32'h0);
      step(6'h12, 1, 0, 0, 1, 0, 1);
      check("t1_mflo_data", s_rd, 32'h0);

      // MTHI then reads.
      step(6'h11, 1, 0, 0, 1, 32'hDEADBEEF, 1);
      step(6'h10, 1, 0, 0, 1, 0, 1);
      check("t2_mfhi_data", s_rd, 32'hDEADBEEF);
      check("t2_mfhi_stall", {31'b0, s_stall}, 32'h0);
      step(6'h12, 1, 0, 0, 1, 0, 1);
      check("t2_mflo_data", s_rd, 32'h0);

      // MULT latency seen by an immediately following MFLO.
      step(6'h18, 1, 32'h1, 32'h2, 1, 0, 1);
      n = 0;
      do begin
         step(6'h12, 1, 0, 0, 1, 0, 1);
         if (s_stall) n++;
      end while (s_stall && n < 40);
      check("t3_stall_cycles", n, FWD ? 32'd3 : 32'd4);
      check("t3_mflo_data", s_rd, 32'h2);
      step(6'h10, 1, 0, 0, 1, 0, 1);
      check("t3_mfhi_data", s_rd, 32'h1);

      // Divide by zero leaves state untouched.
      step(6'h13, 1, 0, 0, 1, 32'h55, 1);
      step(6'h1A, 1, 32'h99, 32'h77, 32'h0, 0, 1);
      check("t4_div0_stall", {31'b0, s_stall}, 32'h0);
      step(6'h12, 1, 0, 0, 1, 0, 1);
      check("t4_busy", {31'b0, s_busy}, 32'h0);
      check("t4_mflo_data", s_rd, 32'h55);

      // Back-to-back MULT / MULTU.
      step(6'h18, 1, 32'h3, 32'h4, 1, 0, 1);
      n = 0;
      do begin
         step(6'h19, 1, 32'h7, 32'h8, 1, 0, 1);
         if (s_stall) n++;
      end while (s_stall && n < 40);
      check("t6_multu_stalls", n, 32'd4);
      n = 0;
      do begin
         nop(1'b1);
         n++;
      end while (s_busy && n < 40);
      check("t6_busy_cycles", n, 32'd5);
      step(6'h10, 1, 0, 0, 1, 0, 1);
      check("t6_mfhi_data", s_rd, 32'h7);
      step(6'h12, 1, 0, 0, 1, 0, 1);
      check("t6_mflo_data", s_rd, 32'h8);

      // Randomized traffic including occasional resets and zero divisors.
      for (int i = 0; i < 2000; i++) begin
         o2 = ($urandom_range(3) == 0) ? 32'h0 : $urandom;
         step(ops[$urandom_range(9)], $urandom_range(9) != 0, $urandom, $urandom, o2, $urandom,
              $urandom_range(199) != 0);
      end

      // Reset in the middle of a DIVU discards the pending result.
      nop(1'b0);
      step(6'h11, 1, 0, 0, 1, 32'h1234, 1);
      step(6'h1B, 1, 32'hAA, 32'hBB, 32'h3, 0, 1);
      nop(1'b1);
      nop(1'b0);
      nop(1'b1);
      check("t5_busy_after_reset", {31'b0, s_busy}, 32'h0);
      for (int i = 0; i < 35; i++) nop(1'b1);
      step(6'h10, 1, 0, 0, 1, 0, 1);
      check("t5_mfhi_data", s_rd, 32'h0);
      step(6'h12, 1, 0, 0, 1, 0, 1);
      check("t5_mflo_data", s_rd, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
